hdmi_video_timing: RTL and testbench

- Generates 640x480@60 raster timing on the 25 MHz pixel clock from the HDMI PLL; runs only while the PLL is locked.
- Provides an early "fetch" stream (pixel coordinates plus request) so the camera framebuffer read path can run ahead of the display.
- Provides a delayed "display" stream (de, hsync, vsync, x, y) aligned with the fetched pixel data, which feeds the TMDS encoders.

---
 rtl/hdmi_timing_pkg.sv | 36 +++
 rtl/timing_delay_line.sv | 27 ++
 rtl/hdmi_video_timing.sv | 149 ++++++++++++++
 tb/tb_hdmi_video_timing.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared raster constants for the HDMI output path: 640x480@60 timing,
// frame/line totals and the display-side signal bundle.
package hdmi_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit DEF_SYNC_POL  = 1'b0;
  localparam int DEF_FETCH_LAT = 2;

  function automatic int line_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Everything the TMDS side needs for one pixel slot.
  typedef struct packed {
    logic               de;
    logic               hsync;
    logic               vsync;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } disp_t;

endpackage

// File: rtl/timing_delay_line.sv
// Fixed-depth register pipeline with asynchronous reset of every stage to a
// caller-supplied idle word.
module timing_delay_line #(
  parameter int                DEPTH = 2,
  parameter int                WIDTH = 1,
  parameter logic [WIDTH-1:0]  IDLE  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= IDLE;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/hdmi_video_timing.sv
// 640x480 raster generator: an early fetch stream for the framebuffer reader
// and a FETCH_LAT-delayed display stream aligned with the fetched pixel data.
module hdmi_video_timing
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit SYNC_POL  = DEF_SYNC_POL,
  parameter int FETCH_LAT = DEF_FETCH_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               fetch_req,
  output logic [COORD_W-1:0] fetch_x,
  output logic [COORD_W-1:0] fetch_y,
  output logic               frame_start,
  output logic               line_start,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic [COORD_W-1:0] disp_x,
  output logic [COORD_W-1:0] disp_y
);

  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_totals
      $error("hdmi_video_timing: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end
    if (FETCH_LAT < 1 || FETCH_LAT > 8) begin : g_bad_lat
      $error("hdmi_video_timing: FETCH_LAT must be 1..8");
    end
  endgenerate

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t ONE      = coord_t'(1);
  localparam logic   SYNC_ON  = SYNC_POL;
  localparam logic   SYNC_OFF = !SYNC_POL;

  localparam disp_t DISP_IDLE = '{de: 1'b0, hsync: SYNC_OFF, vsync: SYNC_OFF,
                                  x: '0, y: '0};

  coord_t h, v;
  logic   active, hs_on, vs_on, at_origin, at_line;
  logic   hs_f, vs_f;
  disp_t  fetch_disp, disp_q;

  // Raster counters; dropping en parks them at the top-left corner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (!en) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + ONE;
    end else begin
      h <= h + ONE;
    end
  end

  always_comb begin
    active    = 1'b0;
    hs_on     = 1'b0;
    vs_on     = 1'b0;
    at_origin = 1'b0;
    at_line   = 1'b0;
    if (en) begin
      active    = (h < H_ACT_C) && (v < V_ACT_C);
      hs_on     = (h >= HS_START) && (h < HS_END);
      vs_on     = (v >= VS_START) && (v < VS_END);
      at_origin = (h == '0) && (v == '0);
      at_line   = (h == '0) && (v < V_ACT_C);
    end
  end

  // Fetch stage: one register after the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_req   <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      hs_f        <= SYNC_OFF;
      vs_f        <= SYNC_OFF;
    end else begin
      fetch_req   <= active;
      frame_start <= at_origin;
      line_start  <= at_line;
      hs_f        <= hs_on ? SYNC_ON : SYNC_OFF;
      vs_f        <= vs_on ? SYNC_ON : SYNC_OFF;
      if (!en) begin
        fetch_x <= '0;
        fetch_y <= '0;
      end else if (active) begin
        fetch_x <= h;
        fetch_y <= v;
      end
    end
  end

  always_comb begin
    fetch_disp       = DISP_IDLE;
    fetch_disp.de    = fetch_req;
    fetch_disp.hsync = hs_f;
    fetch_disp.vsync = vs_f;
    fetch_disp.x     = fetch_x;
    fetch_disp.y     = fetch_y;
  end

  timing_delay_line #(
    .DEPTH (FETCH_LAT),
    .WIDTH ($bits(disp_t)),
    .IDLE  (DISP_IDLE)
  ) u_disp_delay (
    .clk (clk),
    .rst (rst),
    .d   (fetch_disp),
    .q   (disp_q)
  );

  assign de     = disp_q.de;
  assign hsync  = disp_q.hsync;
  assign vsync  = disp_q.vsync;
  assign disp_x = disp_q.x;
  assign disp_y = disp_q.y;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing: a default 640x480 instance and a shrunken
// raster (FETCH_LAT=5, active-high sync) checked against a position model.
module tb_hdmi_video_timing;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic       fetch_req_a, frame_start_a, line_start_a, de_a, hsync_a, vsync_a;
  logic [9:0] fetch_x_a, fetch_y_a, disp_x_a, disp_y_a;
  logic       fetch_req_b, frame_start_b, line_start_b, de_b, hsync_b, vsync_b;
  logic [9:0] fetch_x_b, fetch_y_b, disp_x_b, disp_y_b;

  hdmi_video_timing u_dut_a (
    .clk(clk), .rst(rst), .en(en),
    .fetch_req(fetch_req_a), .fetch_x(fetch_x_a), .fetch_y(fetch_y_a),
    .frame_start(frame_start_a), .line_start(line_start_a),
    .de(de_a), .hsync(hsync_a), .vsync(vsync_a),
    .disp_x(disp_x_a), .disp_y(disp_y_a)
  );

  hdmi_video_timing #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .FETCH_LAT(5)
  ) u_dut_b (
    .clk(clk), .rst(rst), .en(en),
    .fetch_req(fetch_req_b), .fetch_x(fetch_x_b), .fetch_y(fetch_y_b),
    .frame_start(frame_start_b), .line_start(line_start_b),
    .de(de_b), .hsync(hsync_b), .vsync(vsync_b),
    .disp_x(disp_x_b), .disp_y(disp_y_b)
  );

  // ---------------- reference model ----------------
  localparam int HA[2]  = '{640, 40};
  localparam int HF[2]  = '{16, 4};
  localparam int HS[2]  = '{96, 8};
  localparam int HB[2]  = '{48, 6};
  localparam int VA[2]  = '{480, 12};
  localparam int VF[2]  = '{10, 2};
  localparam int VS[2]  = '{2, 2};
  localparam int VB[2]  = '{33, 3};
  localparam bit POL[2] = '{1'b0, 1'b1};
  localparam int LAT[2] = '{2, 5};

  int          pos [2];
  logic [9:0]  lx  [2];
  logic [9:0]  ly  [2];
  logic [22:0] fexp[2];
  logic [22:0] hist[2][16];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    pos[d]  = 0;
    lx[d]   = '0;
    ly[d]   = '0;
    fexp[d] = '0;
    for (int j = 0; j < 16; j++) hist[d][j] = {1'b0, !POL[d], !POL[d], 20'd0};
  endtask

  // Position is simply "enabled cycles since restart"; h and v fall out of it.
  task automatic model_step(input int d, input logic e);
    int   ht, vt, h, v;
    logic req, hs_on, vs_on, fs, ls, hsl, vsl;
    ht = HA[d] + HF[d] + HS[d] + HB[d];
    vt = VA[d] + VF[d] + VS[d] + VB[d];
    h  = pos[d] % ht;
    v  = (pos[d] / ht) % vt;
    req = 1'b0; hs_on = 1'b0; vs_on = 1'b0; fs = 1'b0; ls = 1'b0;
    if (e) begin
      req   = (h < HA[d]) && (v < VA[d]);
      hs_on = (h >= HA[d] + HF[d]) && (h < HA[d] + HF[d] + HS[d]);
      vs_on = (v >= VA[d] + VF[d]) && (v < VA[d] + VF[d] + VS[d]);
      fs    = (h == 0) && (v == 0);
      ls    = (h == 0) && (v < VA[d]);
      if (req) begin
        lx[d] = 10'(h);
        ly[d] = 10'(v);
      end
      pos[d] = (pos[d] + 1) % (ht * vt);
    end else begin
      lx[d]  = '0;
      ly[d]  = '0;
      pos[d] = 0;
    end
    hsl = hs_on ? POL[d] : !POL[d];
    vsl = vs_on ? POL[d] : !POL[d];
    fexp[d] = {req, lx[d], ly[d], fs, ls};
    for (int j = 15; j > 0; j--) hist[d][j] = hist[d][j-1];
    hist[d][0] = {req, hsl, vsl, lx[d], ly[d]};
  endtask

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) model_reset(d);
      else     model_step(d, en);
    end
  end

  // ---------------- scoreboard (every cycle) ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("a_fetch", 32'({fetch_req_a, fetch_x_a, fetch_y_a, frame_start_a, line_start_a}),
            32'(fexp[0]));
      check("a_disp", 32'({de_a, hsync_a, vsync_a, disp_x_a, disp_y_a}), 32'(hist[0][LAT[0]]));
      check("b_fetch", 32'({fetch_req_b, fetch_x_b, fetch_y_b, frame_start_b, line_start_b}),
            32'(fexp[1]));
      check("b_disp", 32'({de_b, hsync_b, vsync_b, disp_x_b, disp_y_b}), 32'(hist[1][LAT[1]]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_a"}, 32'({fetch_req_a, frame_start_a, line_start_a, de_a, hsync_a, vsync_a,
                            fetch_x_a, fetch_y_a}), 32'({3'b000, 1'b0, 1'b1, 1'b1, 20'd0}));
    check({tag, "_a_disp"}, 32'({disp_x_a, disp_y_a}), 32'd0);
    check({tag, "_b"}, 32'({fetch_req_b, frame_start_b, line_start_b, de_b, hsync_b, vsync_b,
                            fetch_x_b, fetch_y_b, disp_x_b, disp_y_b}), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt_req, cnt_de, cnt_hs, period, cnt_de_b, cnt_vs_b;
    bit found;

    rst = 1'b1;
    en  = 1'b0;
    tick(3);
    check_idle("reset_idle");
    chk_on = 1'b1;
    en  = 1'b1;
    rst = 1'b0;

    // One full line of the 640x480 instance from reset release.
    cnt_req = 0; cnt_de = 0; cnt_hs = 0;
    for (int i = 1; i <= 802; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("first_frame_start", 32'(frame_start_a), 32'd1);
        check("first_fetch_req", 32'(fetch_req_a), 32'd1);
      end
      if (i == 2) check("de_not_yet", 32'(de_a), 32'd0);
      if (i == 3) check("de_first", 32'({de_a, disp_x_a, disp_y_a}), 32'({1'b1, 20'd0}));
      if (i == 801) check("line_start_line1", 32'({line_start_a, frame_start_a}), 32'b10);
      if (i <= 800 && fetch_req_a) cnt_req++;
      if (i >= 3 && de_a) cnt_de++;
      if (!hsync_a) cnt_hs++;
    end
    check("line_fetch_cnt", 32'(cnt_req), 32'd640);
    check("line_de_cnt", 32'(cnt_de), 32'd640);
    check("line_hsync_cnt", 32'(cnt_hs), 32'd96);

    // One full frame of the small instance: 58x19 raster.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = frame_start_b;
    end
    check("b_frame_seen", 32'(found), 32'd1);
    period = 0; cnt_de_b = 0; cnt_vs_b = 0; found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (de_b) cnt_de_b++;
      if (vsync_b) cnt_vs_b++;
      @(negedge clk);
      period++;
      found = frame_start_b;
    end
    check("b_frame_period", 32'(period), 32'd1102);
    check("b_frame_de_cnt", 32'(cnt_de_b), 32'd480);
    check("b_frame_vsync_cnt", 32'(cnt_vs_b), 32'd116);

    // Randomized en drops, mid-line resets and free running.
    for (int it = 0; it < 20 && n_fail < 100; it++) begin
      tick($urandom_range(2500, 40));
      case ($urandom_range(2, 0))
        0: begin
          en = 1'b0;
          tick(1);
          check("en_drop_req", 32'({fetch_req_a, fetch_req_b}), 32'd0);
          tick(2);
          check("en_drop_de_a", 32'(de_a), 32'd0);
          tick($urandom_range(12, 3));
          check("en_low_de_b", 32'(de_b), 32'd0);
          en = 1'b1;
          tick(1);
          check("en_restart", 32'({frame_start_a, fetch_x_a, fetch_y_a, frame_start_b}),
                32'({1'b1, 20'd0, 1'b1}));
        end
        1: begin
          @(posedge clk);
          #3 rst = 1'b1;
          #1 check_idle("async_rst");
          tick($urandom_range(4, 1));
          rst = 1'b0;
          tick(1);
          check("rst_restart", 32'({frame_start_a, fetch_req_a, frame_start_b}), 32'b111);
        end
        default: tick(1);
      endcase
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
